// File: rtl/snax_tcdm_port_buffer.sv
`default_nettype none
// ============================================================================
// Module   : snax_tcdm_port_buffer
// Purpose  : One TCDM port stage: a registered request slice towards the TCDM
//            and a credit-guarded read-response FIFO towards the streamer.
// Revision : 1.0 - initial release
// ============================================================================
module snax_tcdm_port_buffer #(
    parameter int DATA_WIDTH      = 64,
    parameter int TCDM_ADDR_WIDTH = 48,
    parameter int RSP_DEPTH       = 4,
    parameter int CNT_WIDTH       = $clog2(RSP_DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_write_i,
    input  logic [TCDM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]      req_data_i,
    input  logic [DATA_WIDTH/8-1:0]    req_strb_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic                       tcdm_write_o,
    output logic [TCDM_ADDR_WIDTH-1:0] tcdm_addr_o,
    output logic [DATA_WIDTH-1:0]      tcdm_data_o,
    output logic [DATA_WIDTH/8-1:0]    tcdm_strb_o,
    output logic                       tcdm_q_valid_o,
    input  logic                       tcdm_q_ready_i,
    input  logic                       tcdm_p_valid_i,
    input  logic [DATA_WIDTH-1:0]      tcdm_p_data_i,
    output logic [CNT_WIDTH-1:0]       outstanding_o,
    output logic                       idle_o,
    output logic                       rsp_err_o
);

    localparam int                     c_ptr_width = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0]   c_depth     = CNT_WIDTH'(RSP_DEPTH);
    localparam logic [CNT_WIDTH-1:0]   c_cnt_one   = CNT_WIDTH'(1);
    localparam logic [c_ptr_width-1:0] c_ptr_last  = c_ptr_width'(RSP_DEPTH - 1);
    localparam logic [c_ptr_width-1:0] c_ptr_one   = c_ptr_width'(1);

    // Request slice
    logic                       r_full;
    logic                       r_write;
    logic [TCDM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]      r_data;
    logic [DATA_WIDTH/8-1:0]    r_strb;

    // Credits and response FIFO
    logic [CNT_WIDTH-1:0]       r_credits;
    logic [CNT_WIDTH-1:0]       r_count;
    logic [c_ptr_width-1:0]     r_wptr;
    logic [c_ptr_width-1:0]     r_rptr;
    logic [DATA_WIDTH-1:0]      r_mem [RSP_DEPTH];
    logic                       r_err;

    logic w_slot_free;
    logic w_req_ready;
    logic w_req_fire;
    logic w_rd_fire;
    logic w_pop;
    logic w_no_inflight;
    logic w_push;

    assign w_slot_free   = !r_full || tcdm_q_ready_i;
    assign w_req_ready   = w_slot_free && (req_write_i || (r_credits < c_depth));
    assign w_req_fire    = req_valid_i && w_req_ready;
    assign w_rd_fire     = w_req_fire && !req_write_i;
    assign w_pop         = (r_count != '0) && rsp_ready_i;
    // A response is only legal while some credited read has not yet landed in the FIFO.
    assign w_no_inflight = (r_credits == r_count);
    assign w_push        = tcdm_p_valid_i && !w_no_inflight;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_full <= 1'b0;
        end else if (w_req_fire) begin
            r_full <= 1'b1;
        end else if (tcdm_q_ready_i) begin
            r_full <= 1'b0;
        end
    end

    // Payload needs no reset; it is qualified by r_full.
    always_ff @(posedge clk_i) begin
        if (w_req_fire) begin
            r_write <= req_write_i;
            r_addr  <= req_addr_i;
            r_data  <= req_data_i;
            r_strb  <= req_strb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credits <= '0;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_err     <= 1'b0;
        end else begin
            case ({w_rd_fire, w_pop})
                2'b10:   r_credits <= r_credits + c_cnt_one;
                2'b01:   r_credits <= r_credits - c_cnt_one;
                default: r_credits <= r_credits;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wptr <= (r_wptr == c_ptr_last) ? '0 : r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + c_ptr_one;
            end
            if (tcdm_p_valid_i && w_no_inflight) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= tcdm_p_data_i;
        end
    end

    assign req_ready_o    = w_req_ready;
    assign tcdm_q_valid_o = r_full;
    assign tcdm_write_o   = r_write;
    assign tcdm_addr_o    = r_addr;
    assign tcdm_data_o    = r_data;
    assign tcdm_strb_o    = r_strb;
    assign rsp_valid_o    = (r_count != '0);
    assign rsp_data_o     = r_mem[r_rptr];
    assign outstanding_o  = r_credits;
    assign idle_o         = !r_full && (r_credits == '0);
    assign rsp_err_o      = r_err;

endmodule
`default_nettype wire
